// File: rtl/seven_segment_capture.sv
// Recovers hex digits, dots and link health from a sampled active-low multiplexed seven-segment scan.
// Latency: pin change held steady appears on outputs STABLE_CYCLES+2 edges after first sampling edge; no backpressure.
module seven_segment_capture #(
  parameter int NUM_SEGMENTS   = 4,
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NUM_SEGMENTS-1:0]      i_anode,
  input  logic [7:0]                   i_cathode,
  output logic [NUM_SEGMENTS-1:0][3:0] o_encoded,
  output logic [NUM_SEGMENTS-1:0]      o_digit_point,
  output logic [NUM_SEGMENTS-1:0]      o_digit_valid,
  output logic                         o_frame_done,
  output logic                         o_decode_error,
  output logic                         o_multi_anode_error,
  output logic                         o_link_lost
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = NUM_SEGMENTS + 8;

  logic [NUM_SEGMENTS-1:0]      r_anode_m, r_anode_s;
  logic [7:0]                   r_cath_m, r_cath_s;
  logic [1:0]                   r_sync_vld;
  logic [SW-1:0]                r_prev;
  logic [CW-1:0]                r_cnt;
  logic [TW-1:0]                r_idle;
  logic [NUM_SEGMENTS-1:0]      r_mask;
  logic [NUM_SEGMENTS-1:0][3:0] r_encoded;
  logic [NUM_SEGMENTS-1:0]      r_point;
  logic [NUM_SEGMENTS-1:0]      r_valid;
  logic                         r_frame_done;
  logic                         r_decode_error;
  logic                         r_multi_error;
  logic                         r_link_lost;

  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h3F: res = 5'h10; 7'h06: res = 5'h11; 7'h5B: res = 5'h12; 7'h4F: res = 5'h13;
      7'h66: res = 5'h14; 7'h6D: res = 5'h15; 7'h7D: res = 5'h16; 7'h07: res = 5'h17;
      7'h7F: res = 5'h18; 7'h6F: res = 5'h19; 7'h77: res = 5'h1A; 7'h7C: res = 5'h1B;
      7'h39: res = 5'h1C; 7'h5E: res = 5'h1D; 7'h79: res = 5'h1E; 7'h71: res = 5'h1F;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  logic [SW-1:0]           w_samp;
  logic                    w_same;
  logic                    w_accept;
  logic                    w_one_low;
  logic                    w_multi_low;
  logic                    w_digit_acc;
  logic [NUM_SEGMENTS-1:0] w_sel;
  logic [4:0]              w_glyph;
  logic                    w_blank;
  logic                    w_timeout;
  logic [NUM_SEGMENTS-1:0] w_mask_next;

  assign w_samp      = {r_anode_s, r_cath_s};
  assign w_same      = (w_samp == r_prev);
  // The sync-valid gate keeps the cleared sync flops (all anodes low) from being accepted after reset.
  assign w_accept    = r_sync_vld[1] && w_same && (r_cnt == CW'(STABLE_CYCLES - 1));
  assign w_sel       = ~r_anode_s;
  assign w_one_low   = $onehot(w_sel);
  assign w_multi_low = (w_sel != '0) && !w_one_low;
  assign w_digit_acc = w_accept && w_one_low;
  assign w_glyph     = decode_glyph(~r_cath_s[6:0]);
  assign w_blank     = (r_cath_s[6:0] == 7'h7F);
  assign w_timeout   = !w_digit_acc && (r_idle == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_mask_next = (&r_mask) ? '0 : r_mask;
    if (w_digit_acc && (w_glyph[4] || w_blank)) w_mask_next = w_mask_next | w_sel;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_anode_m      <= '0;
      r_anode_s      <= '0;
      r_cath_m       <= '0;
      r_cath_s       <= '0;
      r_sync_vld     <= '0;
      r_prev         <= '0;
      r_cnt          <= '0;
      r_idle         <= '0;
      r_mask         <= '0;
      r_encoded      <= '0;
      r_point        <= '0;
      r_valid        <= '0;
      r_frame_done   <= 1'b0;
      r_decode_error <= 1'b0;
      r_multi_error  <= 1'b0;
      r_link_lost    <= 1'b0;
    end else begin
      r_anode_m    <= i_anode;
      r_anode_s    <= r_anode_m;
      r_cath_m     <= i_cathode;
      r_cath_s     <= r_cath_m;
      r_sync_vld   <= {r_sync_vld[0], 1'b1};
      r_prev       <= w_samp;
      r_frame_done <= &r_mask;
      r_mask       <= w_mask_next;

      if (!r_sync_vld[1])                r_cnt <= '0;
      else if (r_cnt == '0 || !w_same)   r_cnt <= CW'(1);
      else if (r_cnt != CW'(STABLE_CYCLES)) r_cnt <= r_cnt + CW'(1);

      if (w_accept && w_multi_low) r_multi_error <= 1'b1;

      if (w_digit_acc) begin
        r_idle      <= '0;
        r_link_lost <= 1'b0;
        for (int i = 0; i < NUM_SEGMENTS; i++) begin
          if (w_sel[i]) begin
            if (w_glyph[4]) begin
              r_encoded[i] <= w_glyph[3:0];
              r_point[i]   <= ~r_cath_s[7];
              r_valid[i]   <= 1'b1;
            end else if (w_blank) begin
              r_point[i]   <= ~r_cath_s[7];
              r_valid[i]   <= 1'b0;
            end else begin
              r_valid[i]     <= 1'b0;
              r_decode_error <= 1'b1;
            end
          end
        end
      end else if (w_timeout) begin
        r_idle      <= r_idle + TW'(1);
        r_link_lost <= 1'b1;
        r_valid     <= '0;
        r_mask      <= '0;
      end else if (r_idle != TW'(TIMEOUT_CYCLES)) begin
        r_idle <= r_idle + TW'(1);
      end
    end
  end

  assign o_encoded           = r_encoded;
  assign o_digit_point       = r_point;
  assign o_digit_valid       = r_valid;
  assign o_frame_done        = r_frame_done;
  assign o_decode_error      = r_decode_error;
  assign o_multi_anode_error = r_multi_error;
  assign o_link_lost         = r_link_lost;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: scan patterns, glitches, errors, timeout and frame pulses.
module tb_seven_segment_capture;

  localparam int NS = 4;
  localparam int N  = 8;
  localparam int TO = 100;

  logic             clk = 1'b0;
  logic             reset;
  logic [NS-1:0]    anode;
  logic [7:0]       cathode;
  logic [NS-1:0][3:0] encoded;
  logic [NS-1:0]    digit_point;
  logic [NS-1:0]    digit_valid;
  logic             frame_done;
  logic             decode_error;
  logic             multi_anode_error;
  logic             link_lost;

  int vectors     = 0;
  int miscompares = 0;
  int frames      = 0;
  int f0;

  seven_segment_capture #(
    .NUM_SEGMENTS(NS), .STABLE_CYCLES(N), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_anode(anode), .i_cathode(cathode),
    .o_encoded(encoded), .o_digit_point(digit_point), .o_digit_valid(digit_valid),
    .o_frame_done(frame_done), .o_decode_error(decode_error),
    .o_multi_anode_error(multi_anode_error), .o_link_lost(link_lost)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) frames++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [NS-1:0] a, input logic [7:0] c, input int n);
    anode   = a;
    cathode = c;
    repeat (n) @(negedge clk);
  endtask

  // Digits 0..3 = "1A3F", dot on digit 2 only.
  task automatic scan_1a3f();
    drive(4'b1110, 8'hF9, 50);
    drive(4'b1101, 8'h88, 50);
    drive(4'b1011, 8'h30, 50);
    drive(4'b0111, 8'h8E, 50);
  endtask

  initial begin
    reset   = 1'b1;
    anode   = 4'hF;
    cathode = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_encoded", 32'(encoded), 32'h0);
    chk("rst_point",   32'(digit_point), 32'h0);
    chk("rst_valid",   32'(digit_valid), 32'h0);
    chk("rst_frame",   32'(frame_done), 32'h0);
    chk("rst_errs",    32'({decode_error, multi_anode_error, link_lost}), 32'h0);
    reset = 1'b0;

    // Idle after reset: link_lost rises on the 100th edge.
    repeat (TO - 1) @(negedge clk);
    chk("idle_99", 32'(link_lost), 32'h0);
    @(negedge clk);
    chk("idle_100", 32'(link_lost), 32'h1);

    // Two full scans of "1A3F".
    f0 = frames;
    scan_1a3f();
    scan_1a3f();
    chk("scan_encoded", 32'(encoded), 32'hF3A1);
    chk("scan_point",   32'(digit_point), 32'h4);
    chk("scan_valid",   32'(digit_valid), 32'hF);
    chk("scan_frames",  32'(frames - f0), 32'd2);
    chk("scan_link",    32'(link_lost), 32'h0);

    // Digit 0 shows 8, interrupted by a 5-cycle blank glitch, then held.
    drive(4'b1110, 8'h80, 4);
    drive(4'b1110, 8'hFF, 5);
    chk("glitch_valid", 32'(digit_valid), 32'hF);
    chk("glitch_enc",   32'(encoded), 32'hF3A1);
    drive(4'b1110, 8'h80, N + 1);
    chk("glitch_n1",    32'(encoded), 32'hF3A1);
    @(negedge clk);
    chk("glitch_n2",    32'(encoded), 32'hF3A8);
    repeat (20) @(negedge clk);
    chk("glitch_valid2", 32'(digit_valid), 32'hF);

    // Two anodes low together.
    drive(4'b1100, 8'hF9, 20);
    chk("multi_err",   32'(multi_anode_error), 32'h1);
    chk("multi_enc",   32'(encoded), 32'hF3A8);
    chk("multi_valid", 32'(digit_valid), 32'hF);
    chk("multi_dec",   32'(decode_error), 32'h0);

    // Illegal glyph (segment A only) on digit 1.
    f0 = frames;
    drive(4'b1110, 8'h80, 50);
    drive(4'b1101, 8'hFE, 50);
    drive(4'b1011, 8'h30, 50);
    drive(4'b0111, 8'h8E, 50);
    chk("ill_dec",    32'(decode_error), 32'h1);
    chk("ill_valid",  32'(digit_valid), 32'hD);
    chk("ill_enc",    32'(encoded), 32'hF3A8);
    chk("ill_frames", 32'(frames - f0), 32'd0);

    // Digit 3 blank; blank captures still complete frames.
    f0 = frames;
    repeat (2) begin
      drive(4'b1110, 8'h80, 50);
      drive(4'b1101, 8'h88, 50);
      drive(4'b1011, 8'h30, 50);
      drive(4'b0111, 8'hFF, 50);
    end
    chk("blank_valid",  32'(digit_valid), 32'h7);
    chk("blank_enc",    32'(encoded), 32'hF3A8);
    chk("blank_point",  32'(digit_point), 32'h4);
    chk("blank_frames", 32'(frames - f0), 32'd2);

    // Scan stopped long enough to lose the link.
    drive(4'b1111, 8'hFF, 120);
    chk("loss_link",  32'(link_lost), 32'h1);
    chk("loss_valid", 32'(digit_valid), 32'h0);
    chk("loss_enc",   32'(encoded), 32'hF3A8);

    // Resume: link_lost clears on the first acceptance; timeout emptied the capture mask.
    f0 = frames;
    drive(4'b1110, 8'h80, N + 1);
    chk("resume_n1", 32'(link_lost), 32'h1);
    @(negedge clk);
    chk("resume_n2", 32'(link_lost), 32'h0);
    chk("resume_v0", 32'(digit_valid), 32'h1);
    repeat (40) @(negedge clk);
    drive(4'b1101, 8'h88, 50);
    drive(4'b1011, 8'h30, 50);
    chk("resume_partial", 32'(frames - f0), 32'd0);
    drive(4'b0111, 8'h8E, 50);
    chk("resume_frames", 32'(frames - f0), 32'd1);
    chk("resume_valid",  32'(digit_valid), 32'hF);
    chk("resume_enc",    32'(encoded), 32'hF3A8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
